// File: rtl/top.sv
// Single-cycle MIPS subset core with internal instruction ROM and data RAM.
// Only the data-memory write bus is visible at the ports.
module top #(
  parameter int unsigned IMEM_WORDS = 64,
  parameter int unsigned DMEM_WORDS = 64,
  parameter string       IMEM_FILE  = "memfile.dat"
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] writedata,
  output logic [31:0] dataadr,
  output logic        memwrite
);

  localparam int unsigned IAW = $clog2(IMEM_WORDS);
  localparam int unsigned DAW = $clog2(DMEM_WORDS);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_SLTI  = 6'h0A,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_LUI   = 6'h0F,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_t;

  typedef enum logic [5:0] {
    FN_ADD = 6'h20,
    FN_SUB = 6'h22,
    FN_AND = 6'h24,
    FN_OR  = 6'h25,
    FN_NOR = 6'h27,
    FN_SLT = 6'h2A
  } funct_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_NOR,
    ALU_SLT,
    ALU_LUI
  } aluop_t;

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];
  logic [31:0] rf   [32];

  logic [31:0] pc, pcnext, pcplus4, pcbranch, pcjump;
  logic [31:0] instr;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, waddr;
  logic [15:0] imm;
  logic [31:0] simm, zimm;
  logic [31:0] rdata1, rdata2, srcb, aluout, readdata, wdata;

  logic   regwrite, regdst, alusrc, immzero, memtoreg, mw, branch, brne, jump;
  aluop_t aluop;
  logic   taken;

  assign instr   = imem[pc[IAW+1:2]];
  assign op      = instr[31:26];
  assign rs      = instr[25:21];
  assign rt      = instr[20:16];
  assign rd      = instr[15:11];
  assign funct   = instr[5:0];
  assign imm     = instr[15:0];
  assign simm    = {{16{imm[15]}}, imm};
  assign zimm    = {16'h0000, imm};

  always_comb begin
    regwrite = 1'b0;
    regdst   = 1'b0;
    alusrc   = 1'b0;
    immzero  = 1'b0;
    memtoreg = 1'b0;
    mw       = 1'b0;
    branch   = 1'b0;
    brne     = 1'b0;
    jump     = 1'b0;
    aluop    = ALU_ADD;
    case (opcode_t'(op))
      OP_RTYPE: begin
        regdst = 1'b1;
        case (funct_t'(funct))
          FN_ADD: begin regwrite = 1'b1; aluop = ALU_ADD; end
          FN_SUB: begin regwrite = 1'b1; aluop = ALU_SUB; end
          FN_AND: begin regwrite = 1'b1; aluop = ALU_AND; end
          FN_OR:  begin regwrite = 1'b1; aluop = ALU_OR;  end
          FN_NOR: begin regwrite = 1'b1; aluop = ALU_NOR; end
          FN_SLT: begin regwrite = 1'b1; aluop = ALU_SLT; end
          default: ;
        endcase
      end
      OP_J:    jump = 1'b1;
      OP_BEQ:  branch = 1'b1;
      OP_BNE:  begin branch = 1'b1; brne = 1'b1; end
      OP_ADDI: begin regwrite = 1'b1; alusrc = 1'b1; aluop = ALU_ADD; end
      OP_SLTI: begin regwrite = 1'b1; alusrc = 1'b1; aluop = ALU_SLT; end
      OP_ANDI: begin regwrite = 1'b1; alusrc = 1'b1; immzero = 1'b1; aluop = ALU_AND; end
      OP_ORI:  begin regwrite = 1'b1; alusrc = 1'b1; immzero = 1'b1; aluop = ALU_OR;  end
      OP_LUI:  begin regwrite = 1'b1; alusrc = 1'b1; aluop = ALU_LUI; end
      OP_LW:   begin regwrite = 1'b1; alusrc = 1'b1; memtoreg = 1'b1; end
      OP_SW:   begin alusrc = 1'b1; mw = 1'b1; end
      default: ;
    endcase
  end

  assign rdata1 = (rs == 5'd0) ? '0 : rf[rs];
  assign rdata2 = (rt == 5'd0) ? '0 : rf[rt];
  assign srcb   = alusrc ? (immzero ? zimm : simm) : rdata2;

  always_comb begin
    aluout = '0;
    case (aluop)
      ALU_ADD: aluout = rdata1 + srcb;
      ALU_SUB: aluout = rdata1 - srcb;
      ALU_AND: aluout = rdata1 & srcb;
      ALU_OR:  aluout = rdata1 | srcb;
      ALU_NOR: aluout = ~(rdata1 | srcb);
      ALU_SLT: aluout = {31'd0, $signed(rdata1) < $signed(srcb)};
      ALU_LUI: aluout = {imm, 16'h0000};
      default: aluout = '0;
    endcase
  end

  assign readdata = dmem[aluout[DAW+1:2]];
  assign wdata    = memtoreg ? readdata : aluout;
  assign waddr    = regdst ? rd : rt;

  always_ff @(posedge clk) begin
    if (regwrite && (waddr != 5'd0)) rf[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (memwrite) dmem[aluout[DAW+1:2]] <= rdata2;
  end

  assign pcplus4  = pc + 32'd4;
  assign pcbranch = pcplus4 + {simm[29:0], 2'b00};
  assign pcjump   = {pcplus4[31:28], instr[25:0], 2'b00};
  assign taken    = branch && ((rdata1 == rdata2) != brne);

  always_comb begin
    pcnext = pcplus4;
    if (jump)       pcnext = pcjump;
    else if (taken) pcnext = pcbranch;
  end

  always_ff @(posedge clk) begin
    if (!reset) pc <= '0;
    else        pc <= pcnext;
  end

  assign writedata = rdata2;
  assign dataadr   = aluout;
  assign memwrite  = mw & reset;

  logic unused_shamt;
  assign unused_shamt = ^instr[10:6];

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: runs a fixed program and matches every store
// against a queue of expected (cycle, address, data) entries.
module tb_top;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] writedata, dataadr;
  logic        memwrite;

  top #(.IMEM_WORDS(64), .DMEM_WORDS(64), .IMEM_FILE("")) dut (
    .clk      (clk),
    .reset    (reset),
    .writedata(writedata),
    .dataadr  (dataadr),
    .memwrite (memwrite)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] adr;
    logic [31:0] dat;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] prog [64];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input int c, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.cyc = c;
    e.adr = a;
    e.dat = d;
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    for (int i = 0; i < 64; i++) prog[i] = 32'h0000_0000;
    prog[0]  = 32'h20020005; // addi $2,$0,5
    prog[1]  = 32'h2003000c; // addi $3,$0,12
    prog[2]  = 32'h00432020; // add  $4,$2,$3
    prog[3]  = 32'hac040050; // sw   $4,80($0)
    prog[4]  = 32'h3c05ffff; // lui  $5,0xffff
    prog[5]  = 32'h34a57f02; // ori  $5,$5,0x7f02
    prog[6]  = 32'hac050054; // sw   $5,84($0)
    prog[7]  = 32'h10420001; // beq  $2,$2,+1
    prog[8]  = 32'hac020060; // sw   (skipped)
    prog[9]  = 32'h14420001; // bne  $2,$2,+1 (falls through)
    prog[10] = 32'hac040050; // sw   $4,80($0)
    prog[11] = 32'h0800000d; // j    13
    prog[12] = 32'hac020064; // sw   (skipped)
    prog[13] = 32'h8c060050; // lw   $6,80($0)
    prog[14] = 32'h0066382a; // slt  $7,$3,$6
    prog[15] = 32'h00074022; // sub  $8,$0,$7
    prog[16] = 32'hac080058; // sw   $8,88($0)
    prog[17] = 32'h20000009; // addi $0,$0,9
    prog[18] = 32'hac00005c; // sw   $0,92($0)
    prog[19] = 32'hac040054; // sw   $4,84($0)
    prog[20] = 32'h8c090054; // lw   $9,84($0)
    prog[21] = 32'h01205027; // nor  $10,$9,$0
    prog[22] = 32'h314b00f0; // andi $11,$10,0xf0
    prog[23] = 32'h28acffff; // slti $12,$5,-1
    prog[24] = 32'h01846824; // and  $13,$12,$4
    prog[25] = 32'hfc0d0000; // undefined opcode
    prog[26] = 32'h0184683f; // undefined funct
    prog[27] = 32'h01ab7025; // or   $14,$13,$11
    prog[28] = 32'hac0e0060; // sw   $14,96($0)
    prog[29] = 32'h00a57820; // add  $15,$5,$5
    prog[30] = 32'hac0f0064; // sw   $15,100($0)
    prog[31] = 32'hac0f0150; // sw   $15,0x150($0) (aliases word 80)
    prog[32] = 32'h8c100050; // lw   $16,80($0)
    prog[33] = 32'hac100068; // sw   $16,104($0)
    prog[34] = 32'h0800003e; // j    62
    prog[62] = 32'hac0d006c; // sw   $13,108($0)
    prog[63] = 32'h00000000; // nop, then PC wraps to word 0
    for (int i = 0; i < 64; i++) dut.imem[i] = prog[i];

    push(4,  32'd80,     32'd17);
    push(7,  32'd84,     32'hFFFF7F02);
    push(10, 32'd80,     32'd17);
    push(15, 32'd88,     32'hFFFFFFFF);
    push(17, 32'd92,     32'h0);
    push(18, 32'd84,     32'd17);
    push(27, 32'd96,     32'h000000E1);
    push(29, 32'd100,    32'hFFFEFE04);
    push(30, 32'h150,    32'hFFFEFE04);
    push(32, 32'd104,    32'hFFFEFE04);
    push(34, 32'd108,    32'd1);
    push(39, 32'd80,     32'd17);

    reset = 1'b0;
    @(negedge clk);
    check("rst_mw1", {31'd0, memwrite}, 32'd0);
    @(negedge clk);
    check("rst_mw2", {31'd0, memwrite}, 32'd0);
    reset = 1'b1;

    for (int cyc = 1; cyc <= 60; cyc++) begin
      #1;
      if (memwrite) begin
        if (sb.size() == 0) begin
          check("extra_store_adr", dataadr, 32'hFFFFFFFF);
        end else begin
          e = sb.pop_front();
          check("store_cycle", cyc, e.cyc);
          check("store_adr",   dataadr, e.adr);
          check("store_data",  writedata, e.dat);
        end
      end
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("pending", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
